// File: rtl/id_ex_stage_reg.sv
// ID->EX pipeline register with load-use stall detection and flush bubbling; ID_EX_PERF_CNT_EN adds counters.
// Latency: 1 cycle D->E.
// Backpressure: none from E; load-use holds F/D for exactly one cycle.
module id_ex_stage_reg #(
    parameter int XLEN  = 32,
    parameter int RA_W  = 5,
    parameter int CNT_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              InstrValidD,
    input  logic              RegWriteD,
    input  logic              MemWriteD,
    input  logic              JumpD,
    input  logic              BranchD,
    input  logic              AluSrcD,
    input  logic              JalrD,
    input  logic [1:0]        ResultSrcD,
    input  logic [1:0]        StoreTypeD,
    input  logic [2:0]        LoadTypeD,
    input  logic [2:0]        BranchTypeD,
    input  logic [3:0]        ALUControlD,
    input  logic [XLEN-1:0]   RD1D,
    input  logic [XLEN-1:0]   RD2D,
    input  logic [XLEN-1:0]   ImmExtD,
    input  logic [XLEN-1:0]   PCD,
    input  logic [XLEN-1:0]   PCPlus4D,
    input  logic [RA_W-1:0]   Rs1D,
    input  logic [RA_W-1:0]   Rs2D,
    input  logic [RA_W-1:0]   RdD,
    input  logic              PCSrcE,
    output logic              RegWriteE,
    output logic              MemWriteE,
    output logic              JumpE,
    output logic              BranchE,
    output logic              AluSrcE,
    output logic              JalrE,
    output logic [1:0]        ResultSrcE,
    output logic [1:0]        StoreTypeE,
    output logic [2:0]        LoadTypeE,
    output logic [2:0]        BranchTypeE,
    output logic [3:0]        ALUControlE,
    output logic [XLEN-1:0]   RD1E,
    output logic [XLEN-1:0]   RD2E,
    output logic [XLEN-1:0]   ImmExtE,
    output logic [XLEN-1:0]   PCE,
    output logic [XLEN-1:0]   PCPlus4E,
    output logic [RA_W-1:0]   Rs1E,
    output logic [RA_W-1:0]   Rs2E,
    output logic [RA_W-1:0]   RdE,
    output logic              ValidE,
    output logic              StallF,
    output logic              StallD,
    output logic              FlushD,
    output logic [CNT_W-1:0]  BubbleCnt,
    output logic [CNT_W-1:0]  FlushCnt
);

    typedef struct packed {
        logic            valid;
        logic            regwrite;
        logic            memwrite;
        logic            jump;
        logic            branch;
        logic            alusrc;
        logic            jalr;
        logic [1:0]      resultsrc;
        logic [1:0]      storetype;
        logic [2:0]      loadtype;
        logic [2:0]      branchtype;
        logic [3:0]      aluctl;
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pcplus4;
        logic [RA_W-1:0] rs1;
        logic [RA_W-1:0] rs2;
        logic [RA_W-1:0] rd;
    } ex_t;

    ex_t  ex_q, ex_d;
    logic lw_stall;
    logic bubble;

    // A valid load in E whose destination is a D source; x0 never hazards.
    assign lw_stall = ex_q.valid && ex_q.regwrite && (ex_q.resultsrc == 2'b01) &&
                      (ex_q.rd != '0) && ((ex_q.rd == Rs1D) || (ex_q.rd == Rs2D));
    assign bubble   = lw_stall || PCSrcE || (InstrValidD !== 1'b1);

    assign StallF = lw_stall;
    assign StallD = lw_stall;
    assign FlushD = PCSrcE;

    always_comb begin
        ex_d = '0;
        if (!bubble) begin
            ex_d.valid      = 1'b1;
            // Undriven control bits on unrelated opcodes must not become 1 in E.
            ex_d.regwrite   = (RegWriteD === 1'b1);
            ex_d.memwrite   = (MemWriteD === 1'b1);
            ex_d.jump       = (JumpD     === 1'b1);
            ex_d.branch     = (BranchD   === 1'b1);
            ex_d.jalr       = (JalrD     === 1'b1);
            ex_d.alusrc     = AluSrcD;
            ex_d.resultsrc  = ResultSrcD;
            ex_d.storetype  = StoreTypeD;
            ex_d.loadtype   = LoadTypeD;
            ex_d.branchtype = BranchTypeD;
            ex_d.aluctl     = ALUControlD;
            ex_d.rd1        = RD1D;
            ex_d.rd2        = RD2D;
            ex_d.imm        = ImmExtD;
            ex_d.pc         = PCD;
            ex_d.pcplus4    = PCPlus4D;
            ex_d.rs1        = Rs1D;
            ex_d.rs2        = Rs2D;
            ex_d.rd         = RdD;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) ex_q <= '0;
        else       ex_q <= ex_d;
    end

    assign ValidE      = ex_q.valid;
    assign RegWriteE   = ex_q.regwrite;
    assign MemWriteE   = ex_q.memwrite;
    assign JumpE       = ex_q.jump;
    assign BranchE     = ex_q.branch;
    assign AluSrcE     = ex_q.alusrc;
    assign JalrE       = ex_q.jalr;
    assign ResultSrcE  = ex_q.resultsrc;
    assign StoreTypeE  = ex_q.storetype;
    assign LoadTypeE   = ex_q.loadtype;
    assign BranchTypeE = ex_q.branchtype;
    assign ALUControlE = ex_q.aluctl;
    assign RD1E        = ex_q.rd1;
    assign RD2E        = ex_q.rd2;
    assign ImmExtE     = ex_q.imm;
    assign PCE         = ex_q.pc;
    assign PCPlus4E    = ex_q.pcplus4;
    assign Rs1E        = ex_q.rs1;
    assign Rs2E        = ex_q.rs2;
    assign RdE         = ex_q.rd;

`ifdef ID_EX_PERF_CNT_EN
    logic [CNT_W-1:0] bubble_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else begin
            if (lw_stall) bubble_cnt_q <= bubble_cnt_q + 1'b1;
            if (PCSrcE)   flush_cnt_q  <= flush_cnt_q + 1'b1;
        end
    end

    assign BubbleCnt = bubble_cnt_q;
    assign FlushCnt  = flush_cnt_q;
`else
    assign BubbleCnt = '0;
    assign FlushCnt  = '0;
`endif

    // A load sitting in E can never be the instruction that resolves a taken branch.
    ID_EX_EXCL: assert property (@(posedge clk) disable iff (reset) !(lw_stall && PCSrcE));

endmodule
